// File: rtl/silly_function_unit.sv
// ---------------------------------------------------------------------------
// silly_function_unit
//
// Purpose:
//   Evaluates the three-input function y = ~b & (a | ~c) combinationally,
//   and derives three registered observers from it: a one-cycle-delayed copy
//   of y, a rising-edge pulse, and a saturating count of cycles with y high.
//
// Parameters:
//   CNT_W   width of the high-cycle counter (legal range 2..32, default 8)
//
// Ports (declaration order is fixed so that a, b, c, y may be connected
// positionally):
//   a, b, c  in   function operands
//   y        out  combinational function result (ignores clk and reset)
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-high reset for the registered outputs
//   y_q      out  y sampled on clk (one cycle of latency)
//   y_rise   out  registered pulse, high for one cycle after a sampled 0->1 of y
//   y_cnt    out  saturating count of rising edges on which y was 1
//
// Reset deassertion is assumed to be synchronous to clk already; no
// synchronizer is included here.
// ---------------------------------------------------------------------------
module silly_function_unit #(
    parameter int CNT_W = 8
) (
    input  logic             a,
    input  logic             b,
    input  logic             c,
    output logic             y,
    input  logic             clk,
    input  logic             reset,
    output logic             y_q,
    output logic             y_rise,
    output logic [CNT_W-1:0] y_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Minimised sum of products ~a~b~c | a~b~c | a~b c. Written with plain
    // operators so X/Z on an input only reaches y when the known inputs do
    // not already force the result (b=1 gives 0, b=0 with c=0 gives 1).
    assign y = ~b & (a | ~c);

    logic             y_smp_q, y_smp_d;
    logic             rise_q,  rise_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    always_comb begin
        // NOTE: every variable gets a default at the top of the block, so no
        // path leaves one unassigned and no latch is inferred.
        y_smp_d = y;
        rise_d  = y & ~y_smp_q;
        cnt_d   = cnt_q;
        // Saturate at all-ones rather than wrapping back to zero.
        if (y && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: only a handful of flops here, all with reset values; the
        // asynchronous reset clears the observers immediately, mid-cycle.
        if (reset) begin
            y_smp_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            y_smp_q <= y_smp_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign y_q    = y_smp_q;
    assign y_rise = rise_q;
    assign y_cnt  = cnt_q;

endmodule

// File: tb/tb_silly_function_unit.sv
// ---------------------------------------------------------------------------
// tb_silly_function_unit
//
// Directed, self-checking bench. Expected values come from a truth-table
// constant and a small cycle model; each expectation is pushed to a queue
// when the stimulus is applied and popped when the DUT output is sampled.
// Inputs change on the falling clock edge; registered outputs are sampled
// on the following falling edge, combinational y 1 time unit after a change.
// ---------------------------------------------------------------------------
module tb_silly_function_unit;

    localparam int CNT_W = 8;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             a, b, c;
    logic             y;
    logic             y_q;
    logic             y_rise;
    logic [CNT_W-1:0] y_cnt;

    silly_function_unit #(.CNT_W(CNT_W)) dut (
        .a      (a),
        .b      (b),
        .c      (c),
        .y      (y),
        .clk    (clk),
        .reset  (reset),
        .y_q    (y_q),
        .y_rise (y_rise),
        .y_cnt  (y_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Truth table indexed by {a,b,c}: 1 for abc = 000, 100, 101.
    logic [7:0] tt;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    // Cycle model state.
    logic m_yq;
    logic m_rise;
    int   m_cnt;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        total_cnt++;
        if (exp_q.size() == 0) begin
            $error("FAIL scoreboard_empty: observed %h with no expected entry", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) pass_cnt++;
            else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
        end
    endtask

    // Called on a falling edge: apply abc, check y, let one rising edge
    // happen, then check the registered outputs against the model.
    task automatic cycle(input logic [2:0] abc);
        logic ym;
        {a, b, c} = abc;
        ym = tt[abc];
        push("y_comb", {31'd0, ym});
        #1;
        check({31'd0, y});
        m_rise = ym & ~m_yq;
        m_yq   = ym;
        if (ym && m_cnt != 255) m_cnt++;
        push("y_q", {31'd0, m_yq});
        push("y_rise", {31'd0, m_rise});
        push("y_cnt", m_cnt);
        @(negedge clk);
        check({31'd0, y_q});
        check({31'd0, y_rise});
        check({24'd0, y_cnt});
    endtask

    // Inputs pass through a glitch value early in the cycle; only the value
    // present at the rising edge may count.
    task automatic cycle_glitch(input logic [2:0] glitch, input logic [2:0] abc);
        {a, b, c} = glitch;
        #2;
        cycle(abc);
    endtask

    // Called on a falling edge: assert reset, check the immediate clear,
    // then release reset on the next falling edge.
    task automatic do_reset();
        reset  = 1'b1;
        m_yq   = 1'b0;
        m_rise = 1'b0;
        m_cnt  = 0;
        push("rst_y_q", 32'd0);
        push("rst_y_rise", 32'd0);
        push("rst_y_cnt", 32'd0);
        #1;
        check({31'd0, y_q});
        check({31'd0, y_rise});
        check({24'd0, y_cnt});
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rise_seen;
        tt     = 8'b0011_0001;
        reset  = 1'b0;
        {a, b, c} = 3'b000;
        m_yq   = 1'b0;
        m_rise = 1'b0;
        m_cnt  = 0;

        // Reset asserted between clock edges must clear outputs at once.
        #2 reset = 1'b1;
        push("init_y_q", 32'd0);
        push("init_y_rise", 32'd0);
        push("init_y_cnt", 32'd0);
        #1;
        check({31'd0, y_q});
        check({31'd0, y_rise});
        check({24'd0, y_cnt});

        // Exhaustive truth table, held in reset to show y ignores it.
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            logic [2:0] abc;
            abc = i[2:0];
            {a, b, c} = abc;
            push($sformatf("tt_abc%b", abc), {31'd0, tt[abc]});
            #1;
            check({31'd0, y});
            @(negedge clk);
        end
        push("tt_cnt_held_in_reset", 32'd0);
        check({24'd0, y_cnt});

        // X propagation.
        a = 1'bx; b = 1'b1; c = 1'bx;
        push("x_b1_forces_0", 32'd0);
        #1 check({31'd0, y});
        a = 1'bx; b = 1'b0; c = 1'b0;
        push("x_b0c0_forces_1", 32'd1);
        #1 check({31'd0, y});
        a = 1'bx; b = 1'b0; c = 1'b1;
        push("x_propagates", {31'd0, 1'bx});
        #1 check({31'd0, y});
        {a, b, c} = 3'b000;
        @(negedge clk);

        // Registered path: 000 then 010.
        reset = 1'b0;
        cycle(3'b000);
        cycle(3'b010);
        cycle(3'b010);

        // Counter saturation: 300 edges of abc=100.
        do_reset();
        for (int i = 0; i < 300; i++) cycle(3'b100);
        push("cnt_saturated", 32'd255);
        check({24'd0, y_cnt});

        // Asynchronous reset mid-count.
        do_reset();
        for (int i = 0; i < 17; i++) cycle(3'b100);
        push("cnt_before_reset", 32'd17);
        check({24'd0, y_cnt});
        reset = 1'b1;
        push("ar_y_q", 32'd0);
        push("ar_y_rise", 32'd0);
        push("ar_y_cnt", 32'd0);
        push("ar_y_follows_100", 32'd1);
        #1;
        check({31'd0, y_q});
        check({31'd0, y_rise});
        check({24'd0, y_cnt});
        check({31'd0, y});
        {a, b, c} = 3'b110;
        push("ar_y_follows_110", 32'd0);
        #1 check({31'd0, y});
        @(negedge clk);
        reset  = 1'b0;
        m_yq   = 1'b0;
        m_rise = 1'b0;
        m_cnt  = 0;
        cycle(3'b100);
        push("post_reset_first_cnt", 32'd1);
        check({24'd0, y_cnt});

        // Alternate 101 / 111 for 20 edges from reset.
        do_reset();
        rise_seen = 0;
        for (int i = 0; i < 20; i++) begin
            cycle((i % 2 == 0) ? 3'b101 : 3'b111);
            if (y_rise === 1'b1) rise_seen++;
        end
        push("hold_cnt", 32'd10);
        check({24'd0, y_cnt});
        push("hold_rise_pulses", 32'd10);
        check(rise_seen);

        // Glitches between edges: only the sampled value counts.
        do_reset();
        cycle_glitch(3'b101, 3'b010);
        cycle_glitch(3'b010, 3'b100);
        cycle_glitch(3'b111, 3'b101);

        push("scoreboard_drained", 32'd0);
        check(exp_q.size() - 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/silly_function_unit.md
SILLY_FUNCTION_UNIT -- requirements
Module: sillyfunction

Interface
REQ-001 Parameter CNT_W, default 8: width of the high-cycle counter, legal range 2..32.
REQ-002 clk  input  1  single clock; all sequential logic updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 a  input  1  function operand a.
REQ-005 b  input  1  function operand b.
REQ-006 c  input  1  function operand c.
REQ-007 y  output  1  combinational function result.
REQ-008 y_q  output  1  y registered on clk.
REQ-009 y_rise  output  1  one-cycle pulse on a registered 0->1 transition of y.
REQ-010 y_cnt  output  CNT_W  saturating count of clock edges on which y was 1.
REQ-011 Port declaration order SHALL be a, b, c, y, clk, reset, y_q, y_rise, y_cnt.
- Positional connection of the first four ports (a, b, c, y) stays valid.
- The remaining ports may be left unconnected.

Function
REQ-012 y SHALL be purely combinational, with no clock or reset dependence: y = ~a&~b&~c | a&~b&~c | a&~b&c, equivalently y = ~b & (a | ~c).
REQ-013 Truth table (abc -> y): 000->1, 001->0, 010->0, 011->0, 100->1, 101->1, 110->0, 111->0.
REQ-014 y SHALL settle within the same delta cycle as any input change, with zero clock latency.
REQ-015 Any X or Z on a, b or c SHALL propagate as X on y.
- Exception: when the known input values already force y to a constant, y takes that constant (for example, b=1 forces y=0).
REQ-016 y_q SHALL take the value of y at every rising clk edge, giving one cycle of latency.
REQ-017 y_rise SHALL be 1 for exactly one cycle following an edge where y=1 and y_q=0; it is registered and 0 otherwise.
REQ-018 y_cnt SHALL increment by 1 on each rising edge where y=1.
REQ-019 y_cnt SHALL hold at all-ones (2^CNT_W-1) once reached and SHALL NOT wrap.
REQ-020 y_cnt SHALL hold its value on edges where y=0.
REQ-021 When y toggles between edges (glitches), only the value sampled at the rising edge affects y_q, y_rise and y_cnt.

Reset
REQ-022 While reset=1, the outputs SHALL be forced immediately, without waiting for a clock edge: y_q=0, y_rise=0, y_cnt=0.
REQ-023 reset SHALL NOT affect y, which continues to follow a, b and c during reset.
REQ-024 Reset asserted mid-count SHALL clear y_cnt at once.
- After reset deassertion, the first rising edge with y=1 sets y_cnt=1, y_q=1 and y_rise=1.
REQ-025 Reset deassertion SHALL be treated as synchronous to clk by the integrator; the block adds no synchronizer.

Verification
REQ-026 Exhaustive truth table: apply all 8 abc combinations, each held 10 time units, with clk free-running at period 10.
- Required: y = 1,0,0,0,1,1,0,0 for abc = 000..111 respectively, checked 1 time unit after each change.
REQ-027 Registered path: with reset low, drive abc=000 then 010 on consecutive edges.
- Required: y_q goes 1 and then 0, each one edge late.
- Required: y_rise pulses once, in the cycle after the first edge.
REQ-028 Counter: with CNT_W=8, hold abc=100 for 300 edges.
- Required: y_cnt reads 255 from edge 255 onward, never 0.
- Required: y_rise is high only in the first cycle.
REQ-029 Asynchronous reset: with y_cnt=17, assert reset midway between clock edges.
- Required: y_cnt=0, y_q=0 and y_rise=0 before the next edge.
- Required: y still reflects abc during reset.
REQ-030 Hold: alternate abc between 101 and 111 each edge for 20 edges, starting from reset.
- Required: y_cnt=10.
- Required: y_rise pulses on every cycle that follows a sampled 0->1 transition of y.
REQ-031 X propagation: drive b=1 with a=X and c=X.
- Required: y=0.
- Then drive b=0, a=X, c=0. Required: y=1.
